// File: rtl/mcp3008_responder.sv
// mcp3008_responder: SPI slave emulating the MCP3008 ADC on the device side.
// Optional LSB-first trailer after B0 enabled by MCP3008_LSB_TRAILER_EN.
module mcp3008_responder #(
    parameter int DATA_W      = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              din,
    output logic              dout,
    output logic              dout_oe,
    input  logic [DATA_W-1:0] adc_data,
    output logic [2:0]        chan,
    output logic              sgl_diff,
    output logic              conv_strobe,
    output logic              busy,
    output logic              frame_done
);

    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        CFG,
        SAMPLE,
        DATA,
        TAIL
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] din_sync;
    logic                   sclk_prev;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   din_s;
    logic                   sclk_rise;
    logic                   sclk_fall;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [CW-1:0]     idx;
    logic [2:0]        cfg_sr, cfg_n;
    logic [DATA_W-1:0] data_q, data_n;
    logic              dout_n, oe_n, busy_n;
    logic [2:0]        chan_n;
    logic              sgl_n, strobe_n, done_n;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign din_s     = din_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign idx       = CW'(DATA_W - 1) - cnt;

    // Bring the SPI pins into the clk domain; cs_n idles deasserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            din_sync  <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            din_sync  <= {din_sync[SYNC_STAGES-2:0], din};
            sclk_prev <= sclk_s;
        end
    end

    // Protocol state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            cfg_sr      <= '0;
            data_q      <= '0;
            dout        <= 1'b0;
            dout_oe     <= 1'b0;
            busy        <= 1'b0;
            chan        <= '0;
            sgl_diff    <= 1'b0;
            conv_strobe <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            cfg_sr      <= cfg_n;
            data_q      <= data_n;
            dout        <= dout_n;
            dout_oe     <= oe_n;
            busy        <= busy_n;
            chan        <= chan_n;
            sgl_diff    <= sgl_n;
            conv_strobe <= strobe_n;
            frame_done  <= done_n;
        end
    end

    // Next-state decode; a deasserted cs_n overrides any sclk activity.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        cfg_n    = cfg_sr;
        data_n   = data_q;
        dout_n   = dout;
        oe_n     = dout_oe;
        busy_n   = busy;
        chan_n   = chan;
        sgl_n    = sgl_diff;
        strobe_n = 1'b0;
        done_n   = 1'b0;
        if (cs_s && state != IDLE) begin
            state_n = IDLE;
            dout_n  = 1'b0;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    dout_n = 1'b0;
                    oe_n   = 1'b0;
                    busy_n = 1'b0;
                    if (!cs_s) begin
                        state_n = WAIT_START;
                        busy_n  = 1'b1;
                        oe_n    = 1'b1;
                    end
                end
                WAIT_START: begin
                    if (sclk_rise && din_s) begin
                        state_n = CFG;
                        cnt_n   = '0;
                    end
                end
                CFG: begin
                    if (sclk_rise) begin
                        cfg_n = {cfg_sr[1:0], din_s};
                        cnt_n = cnt + 1'b1;
                        if (cnt == CW'(3)) begin
                            sgl_n   = cfg_sr[2];
                            chan_n  = {cfg_sr[1:0], din_s};
                            state_n = SAMPLE;
                        end
                    end
                end
                SAMPLE: begin
                    if (sclk_fall) begin
                        data_n   = adc_data;
                        strobe_n = 1'b1;
                        dout_n   = 1'b0;
                        cnt_n    = '0;
                        state_n  = DATA;
                    end
                end
                DATA: begin
                    if (sclk_fall) begin
                        dout_n = data_q[idx];
                        cnt_n  = cnt + 1'b1;
                        if (cnt == CW'(DATA_W - 1)) begin
                            done_n  = 1'b1;
                            cnt_n   = CW'(1);
                            state_n = TAIL;
                        end
                    end
                end
                TAIL: begin
                    if (sclk_fall) begin
`ifdef MCP3008_LSB_TRAILER_EN
                        if (cnt < CW'(DATA_W)) begin
                            dout_n = data_q[cnt];
                            cnt_n  = cnt + 1'b1;
                            if (cnt == CW'(DATA_W - 1)) begin
                                done_n = 1'b1;
                            end
                        end else begin
                            dout_n = 1'b0;
                        end
`else
                        dout_n = 1'b0;
`endif
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: doc/mcp3008_responder.md
Name: mcp3008_responder

Overview:
- Synthesizable SPI slave that emulates the MCP3008 ADC protocol on the device side.
- Decodes start/SGL-DIFF/D2..D0 from the master, requests a sample from a parallel data source, and shifts out the null bit followed by the result MSB-first.
- Used for FPGA loopback and hardware-in-loop testing of mcp3008_interface without a physical ADC.
- All SPI pins are oversampled in the system clock domain; sclk is never used as a clock.

Parameters:
DATA_W, 10, conversion result width (12 allows MCP3208 emulation)
SYNC_STAGES, 2, synchronizer flops on sclk, cs_n and din (minimum 2)

Ports:
clk  in  1  system clock; must be at least 4x the sclk frequency
rst_n  in  1  asynchronous active-low reset
sclk  in  1  SPI data clock from master, asynchronous to clk
cs_n  in  1  active-low chip select from master
din  in  1  master-to-device serial data
dout  out  1  device-to-master serial data
dout_oe  out  1  dout output enable; low means dout is high-Z at the pad
adc_data  in  DATA_W  value to return; latched at the sample point
chan  out  3  decoded D2..D0, held until the next config decode
sgl_diff  out  1  decoded SGL/DIFF bit, held until the next config decode
conv_strobe  out  1  one-clk pulse at the sample point
busy  out  1  high from cs_n synchronized low until cs_n synchronized high
frame_done  out  1  one-clk pulse when the last data bit has been driven

Behaviour:
- Reset values: dout=0, dout_oe=0, chan=0, sgl_diff=0, conv_strobe=0, busy=0, frame_done=0. State=IDLE; synchronizers cleared with cs_n forced to 1.
- Edge detection: rise/fall detected on the synchronized sclk (previous vs current stage).
  - Every dout change occurs SYNC_STAGES+1 clk cycles after the raw sclk falling edge.
  - Every din sample uses the synchronized din aligned with the synchronized sclk rise.
- States:
  - IDLE: dout_oe=0. Synchronized cs_n low -> WAIT_START; busy=1, dout_oe=1, dout=0.
  - WAIT_START: on each sclk rise, din=1 -> CFG (bit count 0). din=0 keeps the state, so leading zeros are ignored.
  - CFG: four sclk rises shift in SGL/DIFF, D2, D1, D0. On the 4th rise, chan and sgl_diff update in the same cycle -> SAMPLE.
  - SAMPLE: on the next sclk fall, adc_data is latched into the shift register, conv_strobe=1 for one clk, dout=0 (null bit) -> DATA (count 0).
  - DATA: on each sclk fall, drive the next bit MSB-first, B(DATA_W-1) down to B0.
    - On the fall that drives B0, frame_done=1 for one clk -> TAIL.
  - TAIL: dout=0 on every further sclk fall (behaviour changes under the optional macro). Stays in TAIL until cs_n rises.
- cs_n synchronized high in any state: next cycle -> IDLE, dout_oe=0, dout=0, busy=0. This applies mid-config and mid-data (abort).
  - An abort suppresses any later conv_strobe and frame_done.
  - chan and sgl_diff keep their last decoded values.
- sclk edges while in IDLE are ignored.
- sclk rise and cs_n rise in the same synchronized cycle: the cs_n rise wins.
- adc_data is sampled only in the conv_strobe cycle. Later changes do not affect the frame in progress.
- A new frame needs cs_n high for at least SYNC_STAGES+1 clk. Each frame restarts from WAIT_START.

Optional Feature:
- Macro MCP3008_LSB_TRAILER_EN.
- Defined: after B0, further sclk falls drive B1, B2, ... B(DATA_W-1), matching the MCP3008 LSB-first trailer.
  - frame_done pulses again on the fall that drives B(DATA_W-1).
  - After that, dout=0 until cs_n rises.
- Undefined: TAIL drives 0 only, and frame_done pulses once per frame.

Test Plan:
- Reset: assert rst_n=0 with sclk toggling and cs_n=0 -> every output 0 and dout_oe=0. After release with cs_n=1 -> busy stays 0.
- Single-ended ch5 read: adc_data=10'h2A5, din=1,1,1,0,1, then 11 more sclk periods -> chan=5, sgl_diff=1, one conv_strobe. dout on the falls is 0,1,0,1,0,1,0,0,1,0,1; one frame_done.
- Leading zeros: din=0,0,0,1,0,1,1,0 (differential ch6) -> start found on the 4th rise; chan=6, sgl_diff=0; data returned correctly.
- Mid-data abort: raise cs_n after 4 data bits -> within SYNC_STAGES+1 clk, dout_oe=0 and busy=0; no frame_done. The next full frame returns correct data.
- Data stability: change adc_data to 10'h000 one clk after conv_strobe -> shifted data is still 10'h2A5.
- Extra clocks: 20 sclk falls after config with adc_data=10'h301.
  - Without macro: bits after B0 are all 0.
  - With MCP3008_LSB_TRAILER_EN: trailer is 0,0,0,0,0,0,0,1,1 (B1..B9); frame_done pulses twice.
